// File: rtl/io_uart_in.sv
// io_uart_in: dma_io-bus UART receive peripheral.
// The serial line is synchronised, deserialised LSB first into a byte FIFO and exposed
// through three word registers (RXDATA, STATUS, CTRL) at IO_BASE+0..+2. A one-cycle
// interrupt accompanies every byte that actually lands in the FIFO.
// Optional even-parity reception is compiled in with IO_UART_IN_PARITY_EN.
module io_uart_in #(
    parameter logic [13:0] IO_BASE     = 14'h3F30,
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_in,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic        ext_uart_rx_interrupt_1shot
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

`ifdef IO_UART_IN_PARITY_EN
    // Even parity of a received byte: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // Line synchroniser and edge-detect history; the line idles high.
    logic rx_meta_r, rx_sync_r, rx_prev_r;

    // Receiver state.
    state_t      state_r, state_n;
    logic [15:0] cnt_r, cnt_n;
    logic [15:0] div_lat_r, div_lat_n;
    logic [7:0]  shift_r, shift_n;
    logic [2:0]  bit_r, bit_n;
    logic [15:0] div_eff_s;
    logic        push_s, frame_set_s, parity_set_s, par_bad_s;

    // Control and status.
    logic [15:0] ctrl_div_r;
    logic        rx_enable_r, int_enable_r;
    logic        overrun_r, frame_err_r;
    logic        parity_en_s, parity_err_s;

    // FIFO.
    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               nonempty_s, full_s, do_push_s, pop_s, flush_s, overrun_set_s;
    logic [7:0]         head_s;

    // Bus decode and read path.
    logic        wr_stat_s, wr_ctrl_s;
    logic        rd_sel_data_s, rd_sel_stat_s, rd_sel_ctrl_s, rd_hit_s;
    logic [31:0] status_s, ctrl_s, rd_word_s;
    logic        rd_valid_r;
    logic [31:0] rdata_r;
    logic        irq_r;
    logic        unused_s;

`ifdef IO_UART_IN_PARITY_EN
    logic parity_en_r, parity_err_r, par_bad_r, par_bad_n;
    assign parity_en_s  = parity_en_r;
    assign parity_err_s = parity_err_r;
    assign par_bad_s    = par_bad_r;
`else
    assign parity_en_s  = 1'b0;
    assign parity_err_s = 1'b0;
    assign par_bad_s    = 1'b0;
`endif

    assign unused_s = &{1'b0, dma_io_wdata[31:19]};

    assign div_eff_s  = (ctrl_div_r < 16'd4) ? 16'd4 : ctrl_div_r;
    assign nonempty_s = (count_r != {(FIFO_AW + 1){1'b0}});
    assign full_s     = (count_r == FULL_CNT);
    assign head_s     = mem_r[rd_ptr_r];

    assign wr_stat_s     = dma_io_we && (dma_io_wadr == (IO_BASE + 14'd1));
    assign wr_ctrl_s     = dma_io_we && (dma_io_wadr == (IO_BASE + 14'd2));
    assign rd_sel_data_s = (dma_io_radr == IO_BASE);
    assign rd_sel_stat_s = (dma_io_radr == (IO_BASE + 14'd1));
    assign rd_sel_ctrl_s = (dma_io_radr == (IO_BASE + 14'd2));
    assign rd_hit_s      = dma_io_radr_en && (rd_sel_data_s || rd_sel_stat_s || rd_sel_ctrl_s);

    assign flush_s       = wr_ctrl_s && dma_io_wdata[18];
    assign pop_s         = dma_io_radr_en && rd_sel_data_s && nonempty_s;
    assign do_push_s     = push_s && (!full_s || pop_s);
    assign overrun_set_s = push_s && full_s && !pop_s;

    assign dma_io_rdata                = rd_valid_r ? rdata_r : dma_io_rdata_in;
    assign ext_uart_rx_interrupt_1shot = irq_r;

    // Two-flop synchroniser on the asynchronous line plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver next-state: bit timing, sampling and end-of-frame verdict.
    always_comb begin
        state_n      = state_r;
        cnt_n        = cnt_r;
        div_lat_n    = div_lat_r;
        shift_n      = shift_r;
        bit_n        = bit_r;
        push_s       = 1'b0;
        frame_set_s  = 1'b0;
        parity_set_s = 1'b0;
`ifdef IO_UART_IN_PARITY_EN
        par_bad_n    = par_bad_r;
`endif
        if (!rx_enable_r) begin
            // Disabling abandons any partial frame silently.
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_prev_r && !rx_sync_r) begin
                        state_n   = ST_START;
                        cnt_n     = {1'b0, div_eff_s[15:1]};
                        div_lat_n = div_eff_s;
`ifdef IO_UART_IN_PARITY_EN
                        par_bad_n = 1'b0;
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_r == 16'd0) begin
                        if (!rx_sync_r) begin
                            state_n = ST_DATA;
                            cnt_n   = div_lat_r - 16'd1;
                            bit_n   = 3'd0;
                        end else begin
                            // Line was back high at mid start bit: treat as a glitch.
                            state_n = ST_IDLE;
                        end
                    end else begin
                        cnt_n = cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == 16'd0) begin
                        shift_n = {rx_sync_r, shift_r[7:1]};
                        cnt_n   = div_lat_r - 16'd1;
                        bit_n   = bit_r + 3'd1;
                        if (bit_r == 3'd7) begin
                            state_n = parity_en_s ? ST_PARITY : ST_STOP;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end else begin
                        cnt_n = cnt_r - 16'd1;
                    end
                end
`ifdef IO_UART_IN_PARITY_EN
                ST_PARITY: begin
                    if (cnt_r == 16'd0) begin
                        par_bad_n = (rx_sync_r != even_parity(shift_r));
                        cnt_n     = div_lat_r - 16'd1;
                        state_n   = ST_STOP;
                    end else begin
                        cnt_n = cnt_r - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_r == 16'd0) begin
                        state_n = ST_IDLE;
                        if (!rx_sync_r) begin
                            frame_set_s = 1'b1;
                        end else if (par_bad_s) begin
                            parity_set_s = 1'b1;
                        end else begin
                            push_s = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Receiver state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            div_lat_r <= 16'd0;
            shift_r   <= 8'd0;
            bit_r     <= 3'd0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            div_lat_r <= div_lat_n;
            shift_r   <= shift_n;
            bit_r     <= bit_n;
        end
    end

`ifdef IO_UART_IN_PARITY_EN
    // Parity enable, sticky parity error and the per-frame parity verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_en_r  <= 1'b0;
            parity_err_r <= 1'b0;
            par_bad_r    <= 1'b0;
        end else begin
            par_bad_r <= par_bad_n;
            if (wr_ctrl_s) begin
                parity_en_r <= dma_io_wdata[19];
            end else begin
                parity_en_r <= parity_en_r;
            end
            if (parity_set_s) begin
                parity_err_r <= 1'b1;
            end else if (wr_stat_s && dma_io_wdata[9]) begin
                parity_err_r <= 1'b0;
            end else begin
                parity_err_r <= parity_err_r;
            end
        end
    end
`endif

    // Control register and sticky error flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_div_r   <= DEFAULT_DIV;
            rx_enable_r  <= 1'b1;
            int_enable_r <= 1'b0;
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_div_r   <= dma_io_wdata[15:0];
                rx_enable_r  <= dma_io_wdata[16];
                int_enable_r <= dma_io_wdata[17];
            end else begin
                ctrl_div_r   <= ctrl_div_r;
                rx_enable_r  <= rx_enable_r;
                int_enable_r <= int_enable_r;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (wr_stat_s && dma_io_wdata[2]) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (frame_set_s) begin
                frame_err_r <= 1'b1;
            end else if (wr_stat_s && dma_io_wdata[3]) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    // Byte FIFO: flush overrides push/pop; a pop frees the slot for a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW + 1){1'b0}};
        end else if (flush_s) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + FIFO_AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, pop_s})
                2'b10:   count_r <= count_r + (FIFO_AW + 1)'(1);
                2'b01:   count_r <= count_r - (FIFO_AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register read mux, evaluated on pre-update state of the read cycle.
    always_comb begin
        status_s                    = 32'd0;
        status_s[0]                 = nonempty_s;
        status_s[1]                 = full_s;
        status_s[2]                 = overrun_r;
        status_s[3]                 = frame_err_r;
        status_s[4 +: FIFO_AW + 1]  = count_r;
        status_s[9]                 = parity_err_s;
        ctrl_s                      = {12'd0, parity_en_s, 1'b0, int_enable_r, rx_enable_r, ctrl_div_r};
        if (rd_sel_data_s) begin
            rd_word_s = nonempty_s ? {23'd0, 1'b1, head_s} : 32'd0;
        end else if (rd_sel_stat_s) begin
            rd_word_s = status_s;
        end else if (rd_sel_ctrl_s) begin
            rd_word_s = ctrl_s;
        end else begin
            rd_word_s = 32'd0;
        end
    end

    // Read data is presented for the single cycle after an addressed read strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            rd_valid_r <= rd_hit_s;
            if (rd_hit_s) begin
                rdata_r <= rd_word_s;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Interrupt pulse for each byte that really entered the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= do_push_s && !flush_s && int_enable_r;
        end
    end

endmodule

// File: tb/tb_io_uart_in.sv
// Testbench for io_uart_in: directed sequence with randomized bytes, divisors and stop bits,
// checked against a queue-based model of the receive FIFO and its flags.
module tb_io_uart_in;

    localparam logic [13:0] BASE = 14'h3F30;
    localparam logic [13:0] A_RX = BASE;
    localparam logic [13:0] A_ST = BASE + 14'd1;
    localparam logic [13:0] A_CT = BASE + 14'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_in;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [7:0] model_q[$];
    bit         m_over, m_frame, m_par;
    int         m_irq;

    // Interrupt monitor.
    int  irq_cnt = 0;
    int  irq_wide = 0;
    logic irq_prev = 1'b0;
    time last_irq_time = 0;

    io_uart_in dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .rx_in                       (rx_in),
        .dma_io_we                   (dma_io_we),
        .dma_io_wadr                 (dma_io_wadr),
        .dma_io_wdata                (dma_io_wdata),
        .dma_io_radr                 (dma_io_radr),
        .dma_io_radr_en              (dma_io_radr_en),
        .dma_io_rdata_in             (dma_io_rdata_in),
        .dma_io_rdata                (dma_io_rdata),
        .ext_uart_rx_interrupt_1shot (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (irq) begin
            irq_cnt       <= irq_cnt + 1;
            last_irq_time <= $time;
            if (irq_prev) irq_wide <= irq_wide + 1;
        end
        irq_prev <= irq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic io_write(input logic [13:0] adr, input logic [31:0] data);
        @(negedge clk);
        dma_io_we = 1'b1; dma_io_wadr = adr; dma_io_wdata = data;
        @(negedge clk);
        dma_io_we = 1'b0; dma_io_wadr = 14'd0; dma_io_wdata = 32'd0;
    endtask

    task automatic io_read(input logic [13:0] adr, output logic [31:0] data);
        @(negedge clk);
        dma_io_radr_en = 1'b1; dma_io_radr = adr;
        @(negedge clk);
        dma_io_radr_en = 1'b0; dma_io_radr = 14'd0;
        data = dma_io_rdata;
    endtask

    // par_mode: 0 no parity bit, 1 correct even parity, 2 wrong parity.
    task automatic send_byte(input logic [7:0] b, input int div, input logic stop, input int par_mode);
        rx_in = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (div) @(negedge clk);
        end
        if (par_mode != 0) begin
            rx_in = (^b) ^ (par_mode == 2);
            repeat (div) @(negedge clk);
        end
        rx_in = stop;
        repeat (div) @(negedge clk);
        rx_in = 1'b1;
        repeat (div + 4) @(negedge clk);
    endtask

    // Model of what the receiver should do with one complete frame.
    task automatic model_rx(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        if (!stop_ok) m_frame = 1'b1;
        else if (!par_ok) m_par = 1'b1;
        else if (model_q.size() < 16) begin
            model_q.push_back(b);
            m_irq++;
        end else m_over = 1'b1;
    endtask

    function automatic logic [31:0] model_status();
        int n;
        n = model_q.size();
        return (32'(n) * 32'd16) + (m_par ? 32'd512 : 32'd0) + (m_frame ? 32'd8 : 32'd0)
             + (m_over ? 32'd4 : 32'd0) + ((n == 16) ? 32'd2 : 32'd0) + ((n > 0) ? 32'd1 : 32'd0);
    endfunction

    function automatic logic [31:0] model_pop();
        if (model_q.size() == 0) return 32'd0;
        return 32'h100 + 32'(model_q.pop_front());
    endfunction

    initial begin
        logic [31:0] rd;
        logic [7:0]  b;
        time         t_start;
        int          lat, dv, eff;
        bit          st_ok;

        rst_n = 1'b0; rx_in = 1'b1; dma_io_we = 1'b0; dma_io_wadr = 14'd0; dma_io_wdata = 32'd0;
        dma_io_radr = 14'd0; dma_io_radr_en = 1'b0; dma_io_rdata_in = 32'hdeadbeef;
        m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0; m_irq = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state: passthrough, no interrupt, empty status, default control.
        check("reset_passthrough", dma_io_rdata, 32'hdeadbeef);
        check("reset_irq", {31'd0, irq}, 32'd0);
        io_read(A_ST, rd); check("reset_status", rd, 32'h0);
        // 434 = 0x1B2 with only rx_enable (bit 16) set.
        io_read(A_CT, rd); check("reset_ctrl", rd, 32'h0001_01B2);
        @(negedge clk); check("passthrough_after_read", dma_io_rdata, 32'hdeadbeef);

        // Basic frame at DIV=16 with interrupts on.
        io_write(A_CT, 32'h0003_0010);
        io_read(A_CT, rd); check("ctrl_readback", rd, 32'h0003_0010);
        t_start = $time;
        send_byte(8'h55, 16, 1'b1, 0); model_rx(8'h55, 1'b1, 1'b1);
        check("irq_count_first", 32'(irq_cnt), 32'(m_irq));
        lat = int'((last_irq_time - t_start) / 10);
        check("irq_latency_window", {31'd0, (lat >= 150 && lat <= 170)}, 32'd1);
        io_read(A_ST, rd); check("status_one", rd, model_status());
        io_read(A_RX, rd); check("rxdata_0x55", rd, model_pop());
        io_read(A_RX, rd); check("rxdata_empty", rd, 32'h0);

        // Bad stop bit: discarded, sticky frame error, write-1-clear.
        send_byte(8'hA5, 16, 1'b0, 0); model_rx(8'hA5, 1'b0, 1'b1);
        io_read(A_ST, rd); check("status_frame_err", rd, model_status());
        check("irq_count_frame", 32'(irq_cnt), 32'(m_irq));
        io_write(A_ST, 32'h8); m_frame = 1'b0;
        io_read(A_ST, rd); check("status_frame_clr", rd, model_status());

        // Overfill: 17 random bytes into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            send_byte(b, 16, 1'b1, 0); model_rx(b, 1'b1, 1'b1);
        end
        io_read(A_ST, rd); check("status_full_overrun", rd, model_status());
        check("irq_count_overfill", 32'(irq_cnt), 32'(m_irq));
        for (int i = 0; i < 16; i++) begin
            io_read(A_RX, rd); check("rxdata_drain", rd, model_pop());
        end
        io_read(A_RX, rd); check("rxdata_drained_empty", rd, 32'h0);
        io_write(A_ST, 32'h4); m_over = 1'b0;
        io_read(A_ST, rd); check("status_overrun_clr", rd, model_status());

        // Flush empties the FIFO and the flush bit reads back 0.
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            send_byte(b, 16, 1'b1, 0); model_rx(b, 1'b1, 1'b1);
        end
        io_read(A_ST, rd); check("status_two", rd, model_status());
        io_write(A_CT, 32'h0007_0010); model_q.delete();
        io_read(A_ST, rd); check("status_flushed", rd, model_status());
        io_read(A_CT, rd); check("ctrl_flush_selfclr", rd, 32'h0003_0010);

        // Short low glitch at DIV=32 is rejected.
        io_write(A_CT, 32'h0003_0020);
        rx_in = 1'b0; repeat (10) @(negedge clk); rx_in = 1'b1;
        repeat (60) @(negedge clk);
        io_read(A_ST, rd); check("status_glitch", rd, model_status());
        check("irq_count_glitch", 32'(irq_cnt), 32'(m_irq));

        // Disable at data bit 3: partial frame dropped, then a clean frame after re-enable.
        io_write(A_CT, 32'h0003_0010);
        fork
            send_byte(8'hC3, 16, 1'b1, 0);
            begin
                repeat (16 * 4 + 6) @(negedge clk);
                io_write(A_CT, 32'h0002_0010);
            end
        join
        io_read(A_ST, rd); check("status_disabled", rd, model_status());
        check("irq_count_disabled", 32'(irq_cnt), 32'(m_irq));
        io_write(A_CT, 32'h0003_0010);
        send_byte(8'h3C, 16, 1'b1, 0); model_rx(8'h3C, 1'b1, 1'b1);
        io_read(A_RX, rd); check("rxdata_0x3c", rd, model_pop());

        // Random divisors (including values below the minimum of 4) and random stop bits.
        for (int i = 0; i < 6; i++) begin
            dv    = int'($urandom_range(0, 24));
            eff   = (dv < 4) ? 4 : dv;
            b     = 8'($urandom);
            st_ok = ($urandom_range(0, 3) != 0);
            io_write(A_CT, 32'h0003_0000 + 32'(dv));
            send_byte(b, eff, st_ok, 0); model_rx(b, st_ok, 1'b1);
            io_read(A_ST, rd); check("status_random", rd, model_status());
        end
        while (model_q.size() > 0) begin
            io_read(A_RX, rd); check("rxdata_random", rd, model_pop());
        end
        io_write(A_ST, 32'hC); m_frame = 1'b0; m_over = 1'b0;
        io_read(A_ST, rd); check("status_random_clr", rd, model_status());

`ifdef IO_UART_IN_PARITY_EN
        io_write(A_CT, 32'h000B_0010);
        b = 8'($urandom);
        send_byte(b, 16, 1'b1, 1); model_rx(b, 1'b1, 1'b1);
        io_read(A_RX, rd); check("rxdata_parity_ok", rd, model_pop());
        b = 8'($urandom);
        send_byte(b, 16, 1'b1, 2); model_rx(b, 1'b1, 1'b0);
        io_read(A_ST, rd); check("status_parity_err", rd, model_status());
        io_write(A_ST, 32'h200); m_par = 1'b0;
        io_read(A_ST, rd); check("status_parity_clr", rd, model_status());
`else
        io_write(A_CT, 32'h000B_0010);
        io_read(A_CT, rd); check("ctrl_no_parity_bit", rd, 32'h0003_0010);
        io_write(A_ST, 32'h200);
        io_read(A_ST, rd); check("status_no_parity_bit", rd, model_status());
`endif
        io_write(A_CT, 32'h0003_0010);

        // Passthrough with random upstream data, and interrupt pulse bookkeeping.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dma_io_rdata_in = $urandom;
            #1 check("passthrough_random", dma_io_rdata, dma_io_rdata_in);
        end
        repeat (4) @(negedge clk);
        check("irq_count_total", 32'(irq_cnt), 32'(m_irq));
        check("irq_single_cycle", 32'(irq_wide), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
